// File: rtl/note_seq_classifier.sv
// ---------------------------------------------------------------------------
// note_seq_classifier
//
// Classifies a sequence of notes entered one at a time with a push button.
// Each accepted note is matched against a small programmable pattern table.
// A terminator note (low 3 bits = 0) closes the sequence. The block then
// reports which pattern matched, or reports an error.
//
// Optional feature macro: NOTE_SEQ_DISPLAY_EN
//   defined   -> display drives an active-low seven-segment code for tipo
//   undefined -> display is tied to all-segments-off and no decoder is built
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   ok          note-entry button strobe, asynchronous to clk
//   nota        note code {tom, note[2:0]}, stable while ok is high
//   clr         synchronous restart to IDLE, the pattern table is kept
//   cfg_we      write {cfg_wild, cfg_note} to table[cfg_pat][cfg_pos]
//   cfg_len_we  write cfg_len to the length of pattern cfg_pat
//   cfg_pat     pattern index
//   cfg_pos     position inside the pattern
//   cfg_note    note to store
//   cfg_wild    entry matches any non-terminator note
//   cfg_len     pattern length, 0 disables the pattern
//   fim         classification finished (DONE or ERR)
//   tipo        0 = no match, k = pattern k-1 matched
//   cfg_busy    high while a sequence is in progress; config writes ignored
//   display     active-low seven-segment code {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module note_seq_classifier #(
  parameter int NOTE_W  = 4,
  parameter int MAX_LEN = 6,
  parameter int N_PAT   = 4,
  localparam int PAT_W  = (N_PAT > 1) ? $clog2(N_PAT) : 1,
  localparam int POS_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int LEN_W  = $clog2(MAX_LEN + 1),
  localparam int TIPO_W = $clog2(N_PAT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ok,
  input  logic [NOTE_W-1:0] nota,
  input  logic              clr,
  input  logic              cfg_we,
  input  logic              cfg_len_we,
  input  logic [PAT_W-1:0]  cfg_pat,
  input  logic [POS_W-1:0]  cfg_pos,
  input  logic [NOTE_W-1:0] cfg_note,
  input  logic              cfg_wild,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              fim,
  output logic [TIPO_W-1:0] tipo,
  output logic              cfg_busy,
  output logic [6:0]        display
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE,
    S_ERR
  } state_t;

  // Table entry layout: {wild, note}.
  localparam int ENT_W = NOTE_W + 1;

  // Power-up pattern table.
  function automatic logic [ENT_W-1:0] rst_entry(input int i, input int p);
    logic [ENT_W-1:0] wild_e, la_e, do_e, re_e, tsi_e;
    wild_e = {1'b1, {NOTE_W{1'b0}}};
    la_e   = {1'b0, NOTE_W'(6)};
    do_e   = {1'b0, NOTE_W'(1)};
    re_e   = {1'b0, NOTE_W'(2)};
    tsi_e  = {1'b0, 1'b1, (NOTE_W-1)'(7)};
    rst_entry = '0;
    if (p < 2 && i < 4) begin
      rst_entry = wild_e;
    end else begin
      case (i)
        0: if (p == 2) rst_entry = la_e;
        1: begin
          if (p == 2) rst_entry = la_e;
          if (p == 3) rst_entry = do_e;
        end
        2: begin
          if (p == 2) rst_entry = la_e;
          if (p == 3) rst_entry = tsi_e;
        end
        3: begin
          if (p == 2) rst_entry = tsi_e;
          if (p == 3) rst_entry = re_e;
        end
        default: rst_entry = '0;
      endcase
    end
  endfunction

  function automatic logic [LEN_W-1:0] rst_len(input int i);
    int l;
    case (i)
      0:       l = 3;
      1, 2, 3: l = 4;
      default: l = 0;
    endcase
    if (l > MAX_LEN) l = MAX_LEN;
    return LEN_W'(l);
  endfunction

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    pos_q, pos_d;
  logic [N_PAT-1:0]    cand_q, cand_d;
  logic                fim_q, fim_d;
  logic [TIPO_W-1:0]   tipo_q, tipo_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                hist_q, hist_d;
  logic [ENT_W-1:0]    tab_q [N_PAT][MAX_LEN];
  logic [ENT_W-1:0]    tab_d [N_PAT][MAX_LEN];
  logic [LEN_W-1:0]    len_q [N_PAT];
  logic [LEN_W-1:0]    len_d [N_PAT];

  logic                pulse;
  logic                is_term;
  logic                found;
  logic [TIPO_W-1:0]   hit_tipo;
  logic [N_PAT-1:0]    enabled;
  logic [N_PAT-1:0]    cand_base;
  logic [N_PAT-1:0]    cand_next;
  logic [ENT_W-1:0]    sel;

  // Button synchronizer; the history flop turns a long press into one pulse.
  always_comb begin
    sync1_d = ok;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  assign pulse    = sync2_q & ~hist_q;
  assign cfg_busy = (state_q != S_IDLE) || (pos_q != '0);

  // Config writes use the registered table, so a pulse in the same cycle
  // still compares against the old contents.
  always_comb begin
    tab_d = tab_q;
    len_d = len_q;
    if (!cfg_busy) begin
      if (cfg_we && int'(cfg_pat) < N_PAT && int'(cfg_pos) < MAX_LEN) begin
        tab_d[cfg_pat][cfg_pos] = {cfg_wild, cfg_note};
      end
      if (cfg_len_we && int'(cfg_pat) < N_PAT) begin
        len_d[cfg_pat] = cfg_len;
      end
    end
  end

  // Classification FSM: next state, candidate mask and registered outputs.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    cand_d    = cand_q;
    fim_d     = fim_q;
    tipo_d    = tipo_q;
    sel       = '0;
    found     = 1'b0;
    hit_tipo  = '0;
    is_term   = (nota[2:0] == 3'd0);

    for (int i = 0; i < N_PAT; i++) begin
      enabled[i] = (len_q[i] != '0);
    end

    // The first note of a sequence starts from every enabled pattern.
    cand_base = (state_q == S_IDLE) ? enabled : cand_q;
    cand_next = cand_base;

    for (int i = 0; i < N_PAT; i++) begin
      sel = '0;
      for (int p = 0; p < MAX_LEN; p++) begin
        if (pos_q == LEN_W'(p)) sel = tab_q[i][p];
      end
      if (len_q[i] <= pos_q ||
          (!sel[NOTE_W] && sel[NOTE_W-1:0] != nota)) begin
        cand_next[i] = 1'b0;
      end
      // Lowest index wins when several patterns end here.
      if (!found && cand_base[i] && len_q[i] == pos_q) begin
        found    = 1'b1;
        hit_tipo = TIPO_W'(i + 1);
      end
    end

    if (clr) begin
      state_d = S_IDLE;
      pos_d   = '0;
      cand_d  = '0;
      fim_d   = 1'b0;
      tipo_d  = '0;
    end else if (pulse && (state_q == S_IDLE || state_q == S_COLLECT)) begin
      if (is_term) begin
        fim_d = 1'b1;
        if (found) begin
          state_d = S_DONE;
          tipo_d  = hit_tipo;
        end else begin
          state_d = S_ERR;
          tipo_d  = '0;
        end
      end else if (pos_q == LEN_W'(MAX_LEN)) begin
        state_d = S_ERR;
        fim_d   = 1'b1;
        tipo_d  = '0;
      end else begin
        pos_d  = pos_q + LEN_W'(1);
        cand_d = cand_next;
        if (cand_next == '0) begin
          state_d = S_ERR;
          fim_d   = 1'b1;
          tipo_d  = '0;
        end else begin
          state_d = S_COLLECT;
        end
      end
    end
  end

  // State, table and synchronizer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      cand_q  <= '0;
      fim_q   <= 1'b0;
      tipo_q  <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      for (int i = 0; i < N_PAT; i++) begin
        len_q[i] <= rst_len(i);
        for (int p = 0; p < MAX_LEN; p++) begin
          tab_q[i][p] <= rst_entry(i, p);
        end
      end
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cand_q  <= cand_d;
      fim_q   <= fim_d;
      tipo_q  <= tipo_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      len_q   <= len_d;
      tab_q   <= tab_d;
    end
  end

  assign fim  = fim_q;
  assign tipo = tipo_q;

`ifdef NOTE_SEQ_DISPLAY_EN
  logic [3:0] digit;

  // Segment order {g,f,e,d,c,b,a}, active low; a dash while not finished.
  always_comb begin
    digit   = 4'(tipo_q);
    display = 7'b0111111;
    if (fim_q) begin
      case (digit)
        4'h0: display = 7'b1000000;
        4'h1: display = 7'b1111001;
        4'h2: display = 7'b0100100;
        4'h3: display = 7'b0110000;
        4'h4: display = 7'b0011001;
        4'h5: display = 7'b0010010;
        4'h6: display = 7'b0000010;
        4'h7: display = 7'b1111000;
        4'h8: display = 7'b0000000;
        4'h9: display = 7'b0010000;
        4'hA: display = 7'b0001000;
        4'hB: display = 7'b0000011;
        4'hC: display = 7'b1000110;
        4'hD: display = 7'b0100001;
        4'hE: display = 7'b0000110;
        default: display = 7'b0001110;
      endcase
    end
  end
`else
  assign display = 7'b1111111;
`endif

endmodule

// File: tb/tb_note_seq_classifier.sv
// ---------------------------------------------------------------------------
// tb_note_seq_classifier
//
// Scoreboard bench for note_seq_classifier. The driver presses notes on the
// ok button and, for the note that should close a sequence, pushes the
// expected tipo and completion cycle. A monitor pops an entry each time fim
// rises. Expectations come from a sequence-level reference model of the
// pattern table.
// ---------------------------------------------------------------------------
module tb_note_seq_classifier;

  localparam int NOTE_W  = 4;
  localparam int MAX_LEN = 6;
  localparam int N_PAT   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ok;
  logic [3:0] nota;
  logic       clr;
  logic       cfg_we;
  logic       cfg_len_we;
  logic [1:0] cfg_pat;
  logic [2:0] cfg_pos;
  logic [3:0] cfg_note;
  logic       cfg_wild;
  logic [2:0] cfg_len;
  logic       fim;
  logic [2:0] tipo;
  logic       cfg_busy;
  logic [6:0] display;

  note_seq_classifier #(
    .NOTE_W (NOTE_W),
    .MAX_LEN(MAX_LEN),
    .N_PAT  (N_PAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ok        (ok),
    .nota      (nota),
    .clr       (clr),
    .cfg_we    (cfg_we),
    .cfg_len_we(cfg_len_we),
    .cfg_pat   (cfg_pat),
    .cfg_pos   (cfg_pos),
    .cfg_note  (cfg_note),
    .cfg_wild  (cfg_wild),
    .cfg_len   (cfg_len),
    .fim       (fim),
    .tipo      (tipo),
    .cfg_busy  (cfg_busy),
    .display   (display)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  logic fim_prev = 1'b0;

  always @(posedge clk) cyc++;

  typedef struct {
    int tipo;
    int cycle;
  } exp_t;

  exp_t exp_q[$];

  // Reference pattern table.
  int m_len  [N_PAT];
  int m_note [N_PAT][MAX_LEN];
  bit m_wild [N_PAT][MAX_LEN];

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int seg_of(input int t);
`ifdef NOTE_SEQ_DISPLAY_EN
    case (t)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      default: return 7'h7F;
    endcase
`else
    return 7'h7F + 0 * t;
`endif
  endfunction

  function automatic int idle_display();
`ifdef NOTE_SEQ_DISPLAY_EN
    return 7'h3F;
`else
    return 7'h7F;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_PAT; i++) begin
      m_len[i] = 0;
      for (int j = 0; j < MAX_LEN; j++) begin
        m_note[i][j] = 0;
        m_wild[i][j] = (j < 2);
      end
    end
    m_len[0] = 3; m_note[0][2] = 6;
    m_len[1] = 4; m_note[1][2] = 6;  m_note[1][3] = 1;
    m_len[2] = 4; m_note[2][2] = 6;  m_note[2][3] = 15;
    m_len[3] = 4; m_note[3][2] = 15; m_note[3][3] = 2;
  endtask

  function automatic bit prefix_ok(input int i, input int seq[$], input int n);
    for (int j = 0; j < n; j++) begin
      if (!m_wild[i][j] && m_note[i][j] != seq[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Sequence-level rules: which note closes the sequence and with what tipo.
  function automatic void classify(input int seq[$], output int tipo_o, output int end_o);
    bit alive;
    tipo_o = 0;
    end_o  = seq.size() - 1;
    for (int k = 0; k < seq.size(); k++) begin
      if (seq[k] % 8 == 0) begin
        end_o = k;
        for (int i = N_PAT - 1; i >= 0; i--) begin
          if (m_len[i] != 0 && m_len[i] == k && prefix_ok(i, seq, k)) tipo_o = i + 1;
        end
        return;
      end
      if (k >= MAX_LEN) begin
        end_o = k;
        return;
      end
      alive = 1'b0;
      for (int i = 0; i < N_PAT; i++) begin
        if (m_len[i] > k && prefix_ok(i, seq, k + 1)) alive = 1'b1;
      end
      if (!alive) begin
        end_o = k;
        return;
      end
    end
  endfunction

  function automatic int rnd_note();
    int n;
    do n = $urandom_range(15, 1); while (n % 8 == 0);
    return n;
  endfunction

  // Press the button for one note; the closing note registers its expectation.
  task automatic apply_stimulus(input int note, input int hold, input bit last, input int exp_tipo);
    exp_t e;
    @(posedge clk);
    #1;
    if (last) begin
      e.tipo  = exp_tipo;
      e.cycle = cyc + 3;
      exp_q.push_back(e);
    end
    nota = 4'(note);
    ok   = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    ok = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    check_output(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_clr();
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    check_output("clr_fim", fim, 0);
    check_output("clr_tipo", tipo, 0);
    check_output("clr_busy", cfg_busy, 0);
    check_output("clr_display", display, idle_display());
  endtask

  task automatic cfg_write(input int pat, input int pos, input int note, input bit wild,
                           input bit we, input bit lwe, input int len, input bit applied);
    @(posedge clk);
    #1;
    cfg_pat    = 2'(pat);
    cfg_pos    = 3'(pos);
    cfg_note   = 4'(note);
    cfg_wild   = wild;
    cfg_we     = we;
    cfg_len_we = lwe;
    cfg_len    = 3'(len);
    @(posedge clk);
    #1;
    cfg_we     = 1'b0;
    cfg_len_we = 1'b0;
    if (applied) begin
      if (we && pos < MAX_LEN) begin
        m_note[pat][pos] = note;
        m_wild[pat][pos] = wild;
      end
      if (lwe) m_len[pat] = len;
    end
  endtask

  // Feed a sequence up to its closing note, then optional ignored notes.
  task automatic run_seq(input int seq[$], input int extra, input int first_hold, input bit clear);
    int t, e;
    classify(seq, t, e);
    for (int k = 0; k <= e; k++) begin
      apply_stimulus(seq[k], (k == 0) ? first_hold : 3, k == e, t);
    end
    for (int k = 0; k < extra; k++) apply_stimulus(rnd_note(), 3, 1'b0, 0);
    wait_drain("sb_drained");
    check_output("fim_hold", fim, 1);
    check_output("tipo_hold", tipo, t);
    if (clear) do_clr();
  endtask

  // Monitor: every rising fim consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (fim && !fim_prev && !reset) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL unexpected_fim: got tipo %0d, expected no completion", tipo);
      end else begin
        e = exp_q.pop_front();
        check_output("tipo", tipo, e.tipo);
        check_output("latency_cycle", cyc, e.cycle);
        check_output("display_done", display, seg_of(e.tipo));
      end
    end
    fim_prev = fim;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s[$];
    int t, e;
    reset = 1'b1; ok = 1'b0; nota = '0; clr = 1'b0;
    cfg_we = 1'b0; cfg_len_we = 1'b0; cfg_pat = '0; cfg_pos = '0;
    cfg_note = '0; cfg_wild = 1'b0; cfg_len = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_fim", fim, 0);
    check_output("rst_tipo", tipo, 0);
    check_output("rst_busy", cfg_busy, 0);
    check_output("rst_display", display, idle_display());
    reset = 1'b0;
    $display("[TB] reset released");

    s = {1, 2, 6, 0};      run_seq(s, 0, 3, 1'b1);
    s = {3, 5, 6, 15, 8};  run_seq(s, 0, 3, 1'b1);
    s = {4, 4, 15, 2, 0};  run_seq(s, 0, 3, 1'b1);
    s = {1, 2, 5};         run_seq(s, 2, 3, 1'b1);
    s = {0};               run_seq(s, 1, 3, 1'b1);

    // Long press counts as a single note.
    s = {1, 2, 6, 0};      run_seq(s, 0, 20, 1'b1);

    // Config write in the same cycle as the first pulse.
    s = {1, 2, 6, 0};
    classify(s, t, e);
    @(posedge clk);
    #1 nota = 4'd1; ok = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    cfg_pat = 2'd0; cfg_pos = 3'd0; cfg_note = 4'd5; cfg_wild = 1'b0; cfg_we = 1'b1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0; ok = 1'b0;
    m_note[0][0] = 5; m_wild[0][0] = 1'b0;
    repeat (3) @(posedge clk);
    check_output("busy_after_first", cfg_busy, 1);
    apply_stimulus(2, 3, 1'b0, 0);
    apply_stimulus(6, 3, 1'b0, 0);
    apply_stimulus(0, 3, 1'b1, t);
    wait_drain("sb_same_cycle");
    do_clr();
    s = {1, 2, 6, 0};      run_seq(s, 0, 3, 1'b1);

    // Full-length all-wild pattern, then one note too many.
    for (int p = 0; p < MAX_LEN; p++) cfg_write(0, p, 1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    cfg_write(0, 0, 1, 1'b1, 1'b1, 1'b1, MAX_LEN, 1'b1);
    s = {};
    for (int k = 0; k < MAX_LEN; k++) s.push_back(rnd_note());
    s.push_back(0);
    run_seq(s, 0, 3, 1'b1);
    s = {};
    for (int k = 0; k <= MAX_LEN; k++) s.push_back(rnd_note());
    run_seq(s, 0, 3, 1'b1);

    // Reset in the middle of a sequence, then reset while DONE.
    apply_stimulus(1, 3, 1'b0, 0);
    apply_stimulus(2, 3, 1'b0, 0);
    #3 reset = 1'b1;
    #1;
    check_output("midrst_fim", fim, 0);
    check_output("midrst_tipo", tipo, 0);
    check_output("midrst_busy", cfg_busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    s = {1, 2, 6, 0};      run_seq(s, 0, 3, 1'b0);
    #3 reset = 1'b1;
    #1;
    check_output("donerst_fim", fim, 0);
    check_output("donerst_tipo", tipo, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    s = {1, 2, 6, 0};      run_seq(s, 0, 3, 1'b1);

    // Writes while busy must not reach the table.
    s = {1, 2, 6, 0};
    classify(s, t, e);
    apply_stimulus(1, 3, 1'b0, 0);
    check_output("busy_mid_seq", cfg_busy, 1);
    cfg_write(0, 2, 5, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    apply_stimulus(2, 3, 1'b0, 0);
    apply_stimulus(6, 3, 1'b0, 0);
    apply_stimulus(0, 3, 1'b1, t);
    wait_drain("sb_busy_write");
    do_clr();

    // Randomized table contents and sequences.
    for (int it = 0; it < 40; it++) begin
      int p, len_p;
      repeat ($urandom_range(3, 0)) begin
        cfg_write($urandom_range(N_PAT - 1, 0), $urandom_range(7, 0), rnd_note(),
                  ($urandom_range(2, 0) == 0), $urandom_range(1, 0), $urandom_range(1, 0),
                  $urandom_range(MAX_LEN, 1), 1'b1);
      end
      s = {};
      p = $urandom_range(N_PAT - 1, 0);
      len_p = m_len[p];
      for (int j = 0; j < len_p; j++) s.push_back(m_wild[p][j] ? rnd_note() : m_note[p][j]);
      if (len_p > 0 && $urandom_range(3, 0) == 0) s[$urandom_range(len_p - 1, 0)] = rnd_note();
      if ($urandom_range(5, 0) == 0) repeat ($urandom_range(2, 1)) s.push_back(rnd_note());
      s.push_back($urandom_range(1, 0) * 8);
      run_seq(s, $urandom_range(1, 0), 3, 1'b1);
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
